// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the PLL-to-CPU reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Width of the shared window/hold counter; never less than one bit.
  function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
    int m;
    m = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rst_seq_sync_ff.sv
// Multi-flop synchronizer for one asynchronous level signal.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Holds the CPU in reset until all PLLs show a stable lock window plus a hold time,
// and counts lock losses that occur while the CPU is running.
//
// state     | meaning
// WAIT_LOCK | waiting for all synchronized lock bits
// STABLE    | counting consecutive all-locked cycles
// HOLD      | window met, CPU reset held with clocks running
// RUN       | CPU released
// FAULT     | lock lost in RUN, single cycle before restarting
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_PLL         = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N_PLL-1:0] pll_locked_i,
  input  logic             clr_cnt_i,
  output logic             cpu_rstn_o,
  output logic             plls_locked_o,
  output logic             ready_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] lock_loss_cnt_o
);

  localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_MAX    = '1;

  logic [N_PLL-1:0] lock_sync;
  logic             all_locked;
  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic             cnt_run;
  logic             loss_hit;

  for (genvar i = 0; i < N_PLL; i++) begin : g_sync
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .d     (pll_locked_i[i]),
      .q     (lock_sync[i])
    );
  end

  // Registered AND feeds both the FSM and the status output, so they never disagree.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) all_locked <= 1'b0;
    else         all_locked <= &lock_sync;
  end

  assign plls_locked_o = all_locked;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= WAIT_LOCK;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_LOCK: if (all_locked) next_state = STABLE;
      STABLE: begin
        if (!all_locked)              next_state = WAIT_LOCK;
        else if (cnt == STABLE_LAST)  next_state = HOLD;
      end
      HOLD: begin
        if (!all_locked)              next_state = WAIT_LOCK;
        else if (cnt == HOLD_LAST)    next_state = RUN;
      end
      RUN:   if (!all_locked) next_state = FAULT;
      FAULT: next_state = WAIT_LOCK;
      default: next_state = WAIT_LOCK;
    endcase
  end

  always_comb begin
    cnt_run  = ((state == STABLE) && (next_state == STABLE)) ||
               ((state == HOLD)   && (next_state == HOLD));
    loss_hit = (state == RUN) && !all_locked;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt <= '0;
    else         cnt <= cnt_run ? cnt + CW'(1) : '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cpu_rstn_o <= 1'b0;
      ready_o    <= 1'b0;
    end else begin
      cpu_rstn_o <= (next_state == RUN);
      ready_o    <= (next_state == RUN);
    end
  end

  // A clear coinciding with a new loss keeps that loss visible.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      lock_loss_cnt_o <= '0;
    else if (clr_cnt_i)
      lock_loss_cnt_o <= loss_hit ? CNT_W'(1) : '0;
    else if (loss_hit && (lock_loss_cnt_o != LOSS_MAX))
      lock_loss_cnt_o <= lock_loss_cnt_o + CNT_W'(1);
  end

  assign state_o = state;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with short windows (8 stable, 4 hold) and a 2-bit loss counter.
module tb_rst_seq;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic [1:0] pll_locked_i = 2'b00;
  logic       clr_cnt_i = 1'b0;
  logic       cpu_rstn_o;
  logic       plls_locked_o;
  logic       ready_o;
  logic [2:0] state_o;
  logic [1:0] lock_loss_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  rst_seq #(
    .N_PLL(2), .SYNC_STAGES(2), .STABLE_CYCLES(8), .HOLD_CYCLES(4), .CNT_W(2)
  ) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .pll_locked_i    (pll_locked_i),
    .clr_cnt_i       (clr_cnt_i),
    .cpu_rstn_o      (cpu_rstn_o),
    .plls_locked_o   (plls_locked_o),
    .ready_o         (ready_o),
    .state_o         (state_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Called with locks just raised after an edge; the next edge is E. Release at E+15.
  task automatic release_check(input string tag, input logic [1:0] cnt_exp);
    tick(1);  chk({tag, " E state"}, state_o, 0);
    tick(2);  chk({tag, " E+2 locked"}, plls_locked_o, 1);
              chk({tag, " E+2 state"}, state_o, 0);
    tick(1);  chk({tag, " E+3 state"}, state_o, 1);
    tick(7);  chk({tag, " E+10 state"}, state_o, 1);
    tick(1);  chk({tag, " E+11 state"}, state_o, 2);
    tick(3);  chk({tag, " E+14 cpu_rstn"}, cpu_rstn_o, 0);
              chk({tag, " E+14 state"}, state_o, 2);
    tick(1);  chk({tag, " E+15 cpu_rstn"}, cpu_rstn_o, 1);
              chk({tag, " E+15 ready"}, ready_o, 1);
              chk({tag, " E+15 state"}, state_o, 3);
              chk({tag, " E+15 count"}, lock_loss_cnt_o, cnt_exp);
  endtask

  // Called in RUN right after an edge; lock[0] is low for 20 sampled edges starting at F.
  task automatic loss_check(input string tag, input logic [1:0] cnt_exp, input logic clr);
    pll_locked_i[0] = 1'b0;
    tick(3);  chk({tag, " F+2 cpu_rstn"}, cpu_rstn_o, 1);
              chk({tag, " F+2 state"}, state_o, 3);
    clr_cnt_i = clr;
    tick(1);  clr_cnt_i = 1'b0;
              chk({tag, " F+3 cpu_rstn"}, cpu_rstn_o, 0);
              chk({tag, " F+3 ready"}, ready_o, 0);
              chk({tag, " F+3 state"}, state_o, 4);
              chk({tag, " F+3 count"}, lock_loss_cnt_o, cnt_exp);
    tick(1);  chk({tag, " F+4 state"}, state_o, 0);
    tick(15);
    pll_locked_i[0] = 1'b1;
  endtask

  initial begin
    #2;
    chk("reset cpu_rstn", cpu_rstn_o, 0);
    chk("reset locked", plls_locked_o, 0);
    chk("reset ready", ready_o, 0);
    chk("reset state", state_o, 0);
    chk("reset count", lock_loss_cnt_o, 0);
    tick(2);
    rstn_i = 1'b1;
    tick(2);
    chk("idle state", state_o, 0);

    // Unstable lock: lock[1] drops for 3 cycles while in STABLE.
    pll_locked_i = 2'b11;
    tick(6);
    chk("unstable in STABLE", state_o, 1);
    pll_locked_i[1] = 1'b0;
    tick(3);
    pll_locked_i[1] = 1'b1;
    chk("unstable count", lock_loss_cnt_o, 0);
    chk("unstable cpu_rstn", cpu_rstn_o, 0);
    release_check("relock", 2'd0);

    // Loss in RUN, then successive losses to saturate the 2-bit counter.
    loss_check("loss1", 2'd1, 1'b0);
    release_check("rel1", 2'd1);
    loss_check("loss2", 2'd2, 1'b0);
    release_check("rel2", 2'd2);
    loss_check("loss3", 2'd3, 1'b0);
    release_check("rel3", 2'd3);
    loss_check("loss4", 2'd3, 1'b0);
    release_check("rel4", 2'd3);
    loss_check("loss5", 2'd3, 1'b0);
    release_check("rel5", 2'd3);
    loss_check("loss6 clr", 2'd1, 1'b1);
    release_check("rel6", 2'd1);

    // Async reset mid-RUN with no clock edge before the check.
    #2;
    rstn_i = 1'b0;
    #1;
    chk("async cpu_rstn", cpu_rstn_o, 0);
    chk("async state", state_o, 0);
    chk("async count", lock_loss_cnt_o, 0);
    chk("async ready", ready_o, 0);
    chk("async locked", plls_locked_o, 0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    release_check("post reset", 2'd0);

    // Clear on its own.
    loss_check("loss7", 2'd1, 1'b0);
    clr_cnt_i = 1'b1;
    tick(1);
    clr_cnt_i = 1'b0;
    chk("clr alone", lock_loss_cnt_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer between the PLL bank and the neorv32 core in the PUF top level. It synchronizes the per-PLL lock flags and waits for a continuous stable-lock window. Only then does it release the CPU reset, after a fixed hold with clocks running. Loss of lock while the CPU runs forces the CPU back into reset and increments a saturating lock-loss counter, exposed for the status LED and for software debug.

## Interface
Parameters:
- N_PLL, 2, number of PLL lock inputs
- SYNC_STAGES, 2, synchronizer depth per lock bit (≥2)
- STABLE_CYCLES, 1024, consecutive all-locked cycles required before hold (≥1)
- HOLD_CYCLES, 16, cycles CPU reset stays asserted after stable window (≥1)
- CNT_W, 8, lock-loss counter width

Ports:
- clk_i  in  1  system clock (96 MHz domain)
- rstn_i  in  1  reset; **one clock; reset is asynchronous and active-low**
- pll_locked_i  in  N_PLL  raw PLL LOCK outputs, asynchronous to clk_i
- clr_cnt_i  in  1  synchronous clear of lock-loss counter
- cpu_rstn_o  out  1  active-low CPU reset, registered
- plls_locked_o  out  1  AND of synchronized lock bits, registered
- ready_o  out  1  high while state is RUN
- state_o  out  3  current FSM state encoding
- lock_loss_cnt_o  out  CNT_W  saturating count of lock losses while in RUN

## Operation
- Reset values: cpu_rstn_o=0, plls_locked_o=0, ready_o=0, state_o=WAIT_LOCK (0), lock_loss_cnt_o=0, all synchronizer flops 0, cycle counter 0.
- Each lock bit passes a SYNC_STAGES-flop synchronizer. all_locked is the AND of the synchronizer outputs, and it also drives plls_locked_o.
- FSM states:
  - WAIT_LOCK=0: all_locked → STABLE, counter cleared.
  - STABLE=1: counter increments each cycle. !all_locked → WAIT_LOCK with no loss count. Counter == STABLE_CYCLES-1 with all_locked → HOLD, counter cleared.
  - HOLD=2: counter increments. !all_locked → WAIT_LOCK. Counter == HOLD_CYCLES-1 → RUN.
  - RUN=3: !all_locked → FAULT and the loss counter increments.
  - FAULT=4: unconditional → WAIT_LOCK after one cycle.
- cpu_rstn_o register = (next_state == RUN). ready_o register = same expression. Both are low in every state except RUN.
- Lock-loss counter:
  - saturates at 2^CNT_W-1
  - clr_cnt_i alone → 0
  - clr_cnt_i in the same cycle as an increment → 1
- A lock glitch shorter than one clk_i period may be missed. That is acceptable: PLL LOCK deassertion is always longer than this.
- rstn_i asserted mid-operation returns everything to reset values immediately, regardless of state.

## Timing
- Release latency: let edge E be the first rising edge at which all pll_locked_i are sampled high. cpu_rstn_o rises at edge E + SYNC_STAGES + 1 + STABLE_CYCLES + HOLD_CYCLES, provided lock holds throughout. Defaults give 1043 cycles.
- Fault latency: a lock bit sampled low at edge F drives cpu_rstn_o low at edge F + SYNC_STAGES + 1. The loss counter updates on that same edge.
- FAULT lasts exactly 1 cycle. A fresh release sequence then requires the full window again.
- rstn_i deassertion is synchronized by the system reset tree upstream. This block treats rstn_i as already glitch-free.

## Structure
- Package rst_seq_pkg holds:
  - state typedef (3-bit): WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3, FAULT=4
  - helper constant for counter width: clog2 of max(STABLE_CYCLES, HOLD_CYCLES)
- Sub-module sync_ff (parameter STAGES, 1-bit, async active-low reset to 0), instantiated N_PLL times in a generate loop.
- Top level instantiates rst_seq between the PLL LOCK outputs and the neorv32 rstn_i. The green LED takes ~plls_locked_o.

## Test plan
Bench parameters: STABLE_CYCLES=8, HOLD_CYCLES=4, SYNC_STAGES=2, N_PLL=2.
- **Clean bring-up:** both locks high from reset release → cpu_rstn_o rises exactly 15 edges after the first sampled-high edge; state_o passes 0→1→2→3; ready_o=1; count=0.
- **Unstable lock:** lock[1] drops for 3 cycles mid-STABLE → state returns to WAIT_LOCK, count stays 0, full 15-edge window restarts after re-lock.
- **Loss in RUN:** lock[0] low for 20 cycles → cpu_rstn_o low 3 edges after the first low sample, one FAULT cycle, count=1, re-release 15 edges after re-lock.
- **Saturation and clear:** CNT_W=2, 5 losses → count=3. Then clr_cnt_i coincident with a 6th loss → count=1. clr_cnt_i alone → 0.
- **Async reset mid-RUN:** rstn_i low asynchronously → cpu_rstn_o=0, state=0, count=0 without a clock edge. After release, the sequence repeats with 15-edge latency.
